pd_scan_ctrl: RTL and testbench
===============================

PD_SCAN_CTRL -- requirements
Module: pd_scan_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request a scan of [lo..hi], sampled in IDLE only.
REQ-004 SHALL have ports lo and hi, input, 4 each, inclusive scan bounds, sampled with start.
REQ-005 SHALL have port abort, input, 1, terminate an active scan.
REQ-006 SHALL have port out_valid, output, 1, current beat is valid.
REQ-007 SHALL have port out_ready, input, 1, consumer accepts the beat.
REQ-008 SHALL have ports out_a (4), out_p (1) and out_d (1), outputs: the value, its prime flag and its divisible-by-3 flag.
REQ-009 SHALL have port busy, output, 1, scan in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at normal scan completion.
REQ-011 SHALL have port err, output, 1, one-cycle pulse when start is given with lo>hi.
REQ-012 SHALL have ports prime_cnt and div3_cnt, output, 5 each, counts of accepted beats with out_p=1 and out_d=1 respectively.

Function
REQ-013 SHALL implement the FSM states IDLE, SCAN and DONE.
REQ-014 SHALL, in IDLE with start=1 and lo<=hi, load cur=lo, clear both counts and enter SCAN on the next edge.
REQ-015 SHALL, in IDLE with start=1 and lo>hi, pulse err for one cycle, stay in IDLE and leave the counts unchanged.
REQ-016 SHALL drive out_valid=1 and busy=1 exactly while in SCAN, with out_a=cur, so the first beat appears 1 cycle after start.
REQ-017 SHALL derive out_p and out_d combinationally from registered out_a through the PD sub-module: P=1 for {2,3,5,7,11,13}; D=1 for {0,3,6,9,12,15}.
REQ-018 SHALL complete a beat transfer only when out_valid and out_ready are both 1; on transfer, add out_p to prime_cnt and out_d to div3_cnt.
REQ-019 SHALL, on transfer with cur==hi, enter DONE; on any other transfer, set cur=cur+1.
REQ-020 SHALL hold out_a stable while out_valid=1 and out_ready=0.
REQ-021 SHALL end the scan on the cur==hi compare, never on 4-bit wrap; hi=15 gives 16 beats at most.
REQ-022 SHALL, in DONE, pulse done for one cycle with busy=0 and return to IDLE on the next edge.
REQ-023 SHALL hold prime_cnt and div3_cnt from done until the next accepted start.
REQ-024 SHALL, in SCAN with abort=1, go to IDLE on the next edge with no done pulse.
REQ-025 SHALL, when abort and a transfer occur in the same cycle, still count the transferred beat.
REQ-026 SHALL ignore start in SCAN and in DONE.
REQ-027 SHALL ignore abort in IDLE and in DONE.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state=IDLE, cur=0, counts=0, out_valid=0, busy=0, done=0 and err=0, including in the middle of a scan.
REQ-029 SHALL accept start on the first clock edge after rst_n deasserts.

Structure
REQ-030 SHALL place the state enum (IDLE, SCAN, DONE) and constants VAL_W=4 and CNT_W=5 in the shared package pd_scan_pkg.
REQ-031 SHALL instantiate the existing PD block once as its only sub-module, with A=out_a.

Verification
REQ-032 SHALL test full range: lo=0, hi=15, out_ready=1 -> 16 beats with out_a 0..15, done 17 cycles after start, prime_cnt=6, div3_cnt=6.
REQ-033 SHALL test single value: lo=5, hi=5 -> one beat with out_a=5, out_p=1, out_d=0, then prime_cnt=1, div3_cnt=0.
REQ-034 SHALL test backpressure: lo=2, hi=4, out_ready pattern 0,1,0,0,1,1 -> out_a holds while stalled, then prime_cnt=2, div3_cnt=1.
REQ-035 SHALL test bad range: lo=9, hi=3 -> err pulses once, out_valid stays 0, counts unchanged.
REQ-036 SHALL test abort and ignored start: lo=0, hi=15, start re-asserted at beat 3, abort with transfer at beat 6 -> no restart, IDLE next cycle, prime_cnt=3, div3_cnt=3, no done.
REQ-037 SHALL test reset mid-scan: rst_n=0 during beat 4 -> all outputs 0 immediately, then a new scan runs correctly after release.

Source files
------------

// File: rtl/pd_scan_pkg.sv
// Shared types and widths for the prime/divisible-by-3 scan controller.
package pd_scan_pkg;

    localparam int unsigned VAL_W = 4;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pd_scan_ctrl_pd.sv
// PD block: classifies a 4-bit value as prime and/or divisible by 3.
module pd_scan_ctrl_pd
    import pd_scan_pkg::*;
(
    input  logic [VAL_W-1:0] a,
    output logic             p,
    output logic             d
);

    // Table lookup of both flags for every 4-bit value.
    always_comb begin
        p = 1'b0;
        d = 1'b0;
        case (a)
            4'd2, 4'd5, 4'd7, 4'd11, 4'd13: p = 1'b1;
            default:                        p = 1'b0;
        endcase
        case (a)
            4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: d = 1'b1;
            default:                              d = 1'b0;
        endcase
        if (a == 4'd3) begin
            p = 1'b1;
        end
    end

endmodule

// File: rtl/pd_scan_ctrl.sv
// Scans an inclusive value range, streaming each value with its prime and
// divisible-by-3 flags over a valid/ready interface and counting both flags.
module pd_scan_ctrl
    import pd_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [VAL_W-1:0] lo,
    input  logic [VAL_W-1:0] hi,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VAL_W-1:0] out_a,
    output logic             out_p,
    output logic             out_d,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] prime_cnt,
    output logic [CNT_W-1:0] div3_cnt
);

    state_t           state;
    logic [VAL_W-1:0] cur;
    logic [VAL_W-1:0] hi_r;
    logic             xfer;

    assign out_a = cur;
    assign xfer  = out_valid & out_ready;

    pd_scan_ctrl_pd u_pd (
        .a (out_a),
        .p (out_p),
        .d (out_d)
    );

    // Scan FSM with registered handshake, status pulses and flag counters.
    // Termination uses the cur==hi compare so hi=15 never relies on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            hi_r      <= '0;
            prime_cnt <= '0;
            div3_cnt  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (lo <= hi) begin
                            cur       <= lo;
                            hi_r      <= hi;
                            prime_cnt <= '0;
                            div3_cnt  <= '0;
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            state     <= SCAN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (xfer) begin
                        prime_cnt <= prime_cnt + {{(CNT_W-1){1'b0}}, out_p};
                        div3_cnt  <= div3_cnt + {{(CNT_W-1){1'b0}}, out_d};
                    end
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (xfer) begin
                        if (cur == hi_r) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cur <= cur + VAL_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pd_scan_ctrl.sv
// Scoreboard bench for pd_scan_ctrl: stimulus pushes expected beats, a
// negedge monitor compares every presented beat against the queue head.
module tb_pd_scan_ctrl;

    typedef struct {
        logic [3:0] a;
        logic       p;
        logic       d;
    } beat_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       abort;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_a;
    logic       out_p;
    logic       out_d;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] prime_cnt;
    logic [4:0] div3_cnt;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;
    int    last_p   = 0;
    int    last_d   = 0;

    pd_scan_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .lo        (lo),
        .hi        (hi),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_p     (out_p),
        .out_d     (out_d),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .prime_cnt (prime_cnt),
        .div3_cnt  (div3_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int k = 2; k * k <= v; k++) begin
            if (v % k == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented beat must match the head of the queue;
    // the head is retired only when the consumer accepts it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    check("beat_a", out_a, exp_q[0].a);
                    check("beat_p", out_p, exp_q[0].p);
                    check("beat_d", out_d, exp_q[0].d);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // mode 0: ready always 1; mode 1: fixed pattern then 1; mode 2: random.
    function automatic logic ready_for(input int mode, input int idx);
        logic [5:0] pat;
        pat = 6'b110010; // bit i = ready in scan cycle i (0,1,0,0,1,1)
        if (mode == 0) return 1'b1;
        if (mode == 1) return (idx < 6) ? pat[idx] : 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic push_range(input int l, input int h, output int ep, output int ed);
        beat_t b;
        ep = 0;
        ed = 0;
        for (int v = l; v <= h; v++) begin
            b.a = 4'(v);
            b.p = is_prime(v);
            b.d = (v % 3 == 0);
            exp_q.push_back(b);
            ep += int'(b.p);
            ed += int'(b.d);
        end
    endtask

    task automatic run_scan(input int l, input int h, input int mode, input int exp_lat);
        int ep, ed, n;
        bit got;
        push_range(l, h, ep, ed);
        lo        = 4'(l);
        hi        = 4'(h);
        start     = 1'b1;
        out_ready = 1'b1;
        n   = 0;
        got = 1'b0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
            if (done) begin
                got = 1'b1;
                break;
            end
            out_ready = ready_for(mode, n - 1);
        end
        check("done_seen", got, 1);
        if (exp_lat > 0) check("done_latency", n, exp_lat);
        check("busy_at_done", busy, 0);
        check("valid_at_done", out_valid, 0);
        check("queue_drained", exp_q.size(), 0);
        check("prime_cnt", prime_cnt, ep);
        check("div3_cnt", div3_cnt, ed);
        last_p = ep;
        last_d = ed;
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("prime_cnt_hold", prime_cnt, ep);
        check("div3_cnt_hold", div3_cnt, ed);
    endtask

    initial begin
        int l, h;
        rst_n     = 1'b0;
        start     = 1'b0;
        lo        = '0;
        hi        = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #13;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_a", out_a, 0);
        check("rst_pcnt", prime_cnt, 0);
        check("rst_dcnt", div3_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full range, start on the first edge after reset release.
        run_scan(0, 15, 0, 17);
        // Single value.
        run_scan(5, 5, 0, 2);
        // Backpressure pattern.
        run_scan(2, 4, 1, 0);

        // Bad range: err pulse, no beats, counts left from the previous scan.
        lo    = 4'd9;
        hi    = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_valid", out_valid, 0);
        check("err_busy", busy, 0);
        @(posedge clk);
        #1;
        check("err_one_cycle", err, 0);
        check("err_valid2", out_valid, 0);
        check("err_pcnt", prime_cnt, last_p);
        check("err_dcnt", div3_cnt, last_d);

        // Abort with transfer at beat 6, start re-asserted at beat 3.
        begin
            int ep, ed;
            push_range(0, 15, ep, ed);
            lo        = 4'd0;
            hi        = 4'd15;
            start     = 1'b1;
            out_ready = 1'b1;
            for (int n = 1; n <= 7; n++) begin
                @(posedge clk);
                #1;
                start = (n == 4);
                if (n == 4) begin
                    lo = 4'd7;
                    hi = 4'd9;
                end
                abort = (n == 7);
            end
            @(posedge clk);
            #1;
            abort = 1'b0;
            exp_q.delete();
            check("abort_valid", out_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_pcnt", prime_cnt, 3);
            check("abort_dcnt", div3_cnt, 3);
            for (int n = 0; n < 3; n++) begin
                @(posedge clk);
                #1;
                check("abort_no_done", done, 0);
                check("abort_no_restart", out_valid, 0);
            end
        end

        // Reset in the middle of a scan, during beat 4.
        begin
            int ep, ed;
            push_range(0, 15, ep, ed);
            lo        = 4'd0;
            hi        = 4'd15;
            start     = 1'b1;
            out_ready = 1'b1;
            for (int n = 1; n <= 5; n++) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            check("pre_rst_a", out_a, 4);
            #2;
            rst_n = 1'b0;
            #1;
            exp_q.delete();
            check("mid_rst_valid", out_valid, 0);
            check("mid_rst_busy", busy, 0);
            check("mid_rst_a", out_a, 0);
            check("mid_rst_pcnt", prime_cnt, 0);
            check("mid_rst_dcnt", div3_cnt, 0);
            check("mid_rst_done", done, 0);
            check("mid_rst_err", err, 0);
            @(negedge clk);
            rst_n = 1'b1;
            run_scan(3, 11, 2, 0);
        end

        // Randomized ranges and backpressure.
        for (int i = 0; i < 8; i++) begin
            l = $urandom_range(0, 15);
            h = $urandom_range(l, 15);
            run_scan(l, h, 2, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
